// File: rtl/cla_seq_add_arb.sv
// Two-requester sequential adder: one SLICE_W-bit carry-lookahead slice is reused
// over N cycles per operation, with round-robin arbitration and a held result.
module cla_seq_add_arb #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic              req1_valid,
    output logic              req0_ready,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic              req0_cin,
    input  logic              req1_cin,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_sum,
    output logic              res_cout,
    output logic              res_id,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    localparam int N     = DATA_W / SLICE_W;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic                carry;
    logic [IDX_W-1:0]    idx;
    logic                ptr;

    logic [SLICE_W-1:0]  sa;
    logic [SLICE_W-1:0]  sb;
    logic [SLICE_W-1:0]  g;
    logic [SLICE_W-1:0]  p;
    logic [SLICE_W:0]    c;
    logic [SLICE_W-1:0]  s;
    logic                c_out;
    logic [DATA_W-1:0]   sum_next;

    // Valid/ready: a requester transfers on an edge where its valid and ready are
    // both high; res_* transfers on an edge where res_valid and res_ready are both high.
    // Readies are only ever raised in IDLE; ptr names the requester that wins a tie.
    assign req0_ready = (state == IDLE) & req0_valid & (~req1_valid | ~ptr);
    assign req1_ready = (state == IDLE) & req1_valid & (~req0_valid |  ptr);
    assign busy       = (state != IDLE);
    assign dbg_state  = state;

    always_comb begin
        sa = '0;
        sb = '0;
        for (int k = 0; k < N; k++) begin
            if (idx == IDX_W'(k)) begin
                sa = a_q[k*SLICE_W +: SLICE_W];
                sb = b_q[k*SLICE_W +: SLICE_W];
            end
        end
    end

    // Each slice carry is the fully expanded lookahead term:
    // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]carry
    always_comb begin
        logic acc;
        logic pp;
        g    = sa & sb;
        p    = sa ^ sb;
        c    = '0;
        c[0] = carry;
        for (int i = 0; i < SLICE_W; i++) begin
            acc = g[i];
            pp  = p[i];
            for (int j = i - 1; j >= 0; j--) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
            c[i+1] = acc | (pp & carry);
        end
        s     = p ^ c[SLICE_W-1:0];
        c_out = c[SLICE_W];
    end

    always_comb begin
        sum_next = res_sum;
        for (int k = 0; k < N; k++) begin
            if (idx == IDX_W'(k)) begin
                sum_next[k*SLICE_W +: SLICE_W] = s;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            ptr       <= 1'b0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_cout  <= 1'b0;
            res_id    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready || req1_ready) begin
                        a_q    <= req1_ready ? req1_a   : req0_a;
                        b_q    <= req1_ready ? req1_b   : req0_b;
                        carry  <= req1_ready ? req1_cin : req0_cin;
                        res_id <= req1_ready;
                        ptr    <= ~req1_ready;
                        idx    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    res_sum <= sum_next;
                    carry   <= c_out;
                    idx     <= idx + IDX_ONE;
                    if (idx == IDX_LAST) begin
                        res_cout  <= c_out;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cla_seq_add_arb.sv
// Bench for cla_seq_add_arb: directed scenarios plus a randomized run checked
// against an arithmetic/arbitration reference model.
module tb_cla_seq_add_arb;

    localparam int DATA_W  = 32;
    localparam int SLICE_W = 8;
    localparam int N       = DATA_W / SLICE_W;
    localparam int EW      = DATA_W + 2;

    logic              clk;
    logic              rst_n;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [DATA_W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic              req0_cin, req1_cin;
    logic              res_valid, res_ready;
    logic [DATA_W-1:0] res_sum;
    logic              res_cout, res_id, busy;
    logic [1:0]        dbg_state;
    logic [EW-1:0]     got;

    int n_vec = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];

    assign got = {res_id, res_cout, res_sum};

    cla_seq_add_arb #(.DATA_W(DATA_W), .SLICE_W(SLICE_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_cin(req0_cin), .req1_cin(req1_cin),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id),
        .busy(busy), .dbg_state(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [EW-1:0] ref_add(input bit id, input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b, input bit cin);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
        return {id, s};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic send(input bit k, input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                        input bit cin, output bit ok);
        ok = 1'b0;
        if (k) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = cin;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = cin;
        end
        for (int t = 0; t < 20; t++) begin
            #1;
            if ((k ? req1_ready : req0_ready) === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        if (k) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_result(output int lat);
        lat = -1;
        for (int t = 0; t < 40; t++) begin
            #1;
            if (res_valid === 1'b1) begin
                lat = t;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_cin = 1'b0; req1_cin = 1'b0;
        @(negedge clk);
        #1;
        n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b exp 0", res_valid); end
        n_vec++; if (res_sum !== '0) begin n_err++; $display("FAIL rst_sum: got %h exp 0", res_sum); end
        n_vec++; if (res_cout !== 1'b0) begin n_err++; $display("FAIL rst_cout: got %b exp 0", res_cout); end
        n_vec++; if (res_id !== 1'b0) begin n_err++; $display("FAIL rst_id: got %b exp 0", res_id); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b exp 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        n_vec++; if (dbg_state !== 2'd0) begin n_err++; $display("FAIL rst_state: got %0d exp 0", dbg_state); end
    endtask

    task automatic test_directed();
        bit                tk[4];
        logic [DATA_W-1:0] ta[4];
        logic [DATA_W-1:0] tbv[4];
        bit                tc[4];
        bit                ok;
        int                lat;
        logic [EW-1:0]     e;
        tk[0] = 0; ta[0] = 32'hFFFF_FFFF; tbv[0] = 32'h0000_0001; tc[0] = 0;
        tk[1] = 0; ta[1] = 32'h00FF_00FF; tbv[1] = 32'h0001_0001; tc[1] = 1;
        tk[2] = 1; ta[2] = $urandom();    tbv[2] = $urandom();    tc[2] = 1;
        tk[3] = 1; ta[3] = 32'h8000_0000; tbv[3] = 32'h7FFF_FFFF; tc[3] = 1;
        for (int i = 0; i < 4; i++) begin
            e = ref_add(tk[i], ta[i], tbv[i], tc[i]);
            send(tk[i], ta[i], tbv[i], tc[i], ok);
            n_vec++; if (ok !== 1'b1) begin n_err++; $display("FAIL dir_accept[%0d]: got %b exp 1", i, ok); end
            req0_a = $urandom(); req0_b = $urandom(); req0_cin = ~req0_cin;
            req1_a = $urandom(); req1_b = $urandom(); req1_cin = ~req1_cin;
            wait_result(lat);
            n_vec++; if (lat !== N) begin n_err++; $display("FAIL dir_latency[%0d]: got %0d exp %0d", i, lat, N); end
            n_vec++; if (got !== e) begin n_err++; $display("FAIL dir_result[%0d]: got %h exp %h", i, got, e); end
            res_ready = 1'b1;
            @(negedge clk);
            res_ready = 1'b0;
            #1;
            n_vec++; if (res_valid !== 1'b0) begin n_err++; $display("FAIL dir_release[%0d]: got %b exp 0", i, res_valid); end
        end
    endtask

    task automatic test_alternate();
        int  n_got;
        bit  new0, new1;
        logic [EW-1:0] e;
        do_reset();
        exp_q.delete();
        n_got = 0;
        res_ready = 1'b1;
        req0_a = $urandom(); req0_b = $urandom(); req0_cin = 1'($urandom_range(0, 1));
        req1_a = $urandom(); req1_b = $urandom(); req1_cin = 1'($urandom_range(0, 1));
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            #1;
            new0 = 1'b0; new1 = 1'b0;
            if (res_valid === 1'b1) begin
                e = exp_q.pop_front();
                n_vec++; if (got !== e) begin n_err++; $display("FAIL alt_result[%0d]: got %h exp %h", n_got, got, e); end
                n_vec++; if (res_id !== n_got[0]) begin n_err++; $display("FAIL alt_order[%0d]: got %b exp %b", n_got, res_id, n_got[0]); end
                n_got++;
            end
            if (req0_ready === 1'b1) begin exp_q.push_back(ref_add(0, req0_a, req0_b, req0_cin)); new0 = 1'b1; end
            if (req1_ready === 1'b1) begin exp_q.push_back(ref_add(1, req1_a, req1_b, req1_cin)); new1 = 1'b1; end
            @(negedge clk);
            if (new0) begin req0_a = $urandom(); req0_b = $urandom(); req0_cin = 1'($urandom_range(0, 1)); end
            if (new1) begin req1_a = $urandom(); req1_b = $urandom(); req1_cin = 1'($urandom_range(0, 1)); end
            if (n_got == 8) break;
        end
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        n_vec++; if (n_got != 8) begin n_err++; $display("FAIL alt_count: got %0d exp 8", n_got); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int lat;
        logic [EW-1:0] e;
        logic [DATA_W-1:0] a, b;
        a = $urandom(); b = $urandom();
        e = ref_add(0, a, b, 1'b1);
        send(0, a, b, 1'b1, ok);
        req1_valid = 1'b1; req1_a = $urandom(); req1_b = $urandom(); req1_cin = 1'b0;
        wait_result(lat);
        n_vec++; if (lat !== N) begin n_err++; $display("FAIL bp_latency: got %0d exp %0d", lat, N); end
        for (int c = 0; c < 3; c++) begin
            n_vec++; if (got !== e) begin n_err++; $display("FAIL bp_hold[%0d]: got %h exp %h", c, got, e); end
            n_vec++; if ({res_valid, req1_ready} !== 2'b10) begin n_err++; $display("FAIL bp_ready[%0d]: got %b exp 10", c, {res_valid, req1_ready}); end
            @(negedge clk);
            #1;
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        #1;
        n_vec++; if ({res_valid, req1_ready} !== 2'b01) begin n_err++; $display("FAIL bp_grant: got %b exp 01", {res_valid, req1_ready}); end
        e = ref_add(1, req1_a, req1_b, req1_cin);
        @(negedge clk);
        req1_valid = 1'b0;
        wait_result(lat);
        n_vec++; if (lat !== N) begin n_err++; $display("FAIL bp_latency2: got %0d exp %0d", lat, N); end
        n_vec++; if (got !== e) begin n_err++; $display("FAIL bp_result2: got %h exp %h", got, e); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        bit ok;
        int lat;
        logic [EW-1:0] e;
        send(0, $urandom(), $urandom(), 1'b1, ok);
        repeat (2) @(negedge clk);
        #1;
        n_vec++; if (dbg_state !== 2'd1) begin n_err++; $display("FAIL mid_state: got %0d exp 1", dbg_state); end
        rst_n = 1'b0;
        #1;
        n_vec++; if ({res_valid, busy, res_cout, res_id} !== 4'b0000) begin n_err++; $display("FAIL mid_flags: got %b exp 0000", {res_valid, busy, res_cout, res_id}); end
        n_vec++; if (res_sum !== '0) begin n_err++; $display("FAIL mid_sum: got %h exp 0", res_sum); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < N + 2; c++) begin
            @(negedge clk);
            #1;
            n_vec++; if ({res_valid, busy} !== 2'b00) begin n_err++; $display("FAIL mid_stale[%0d]: got %b exp 00", c, {res_valid, busy}); end
        end
        req0_a = $urandom(); req0_b = $urandom(); req0_cin = 1'b0;
        req1_a = $urandom(); req1_b = $urandom(); req1_cin = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        n_vec++; if ({req0_ready, req1_ready} !== 2'b10) begin n_err++; $display("FAIL mid_ptr: got %b exp 10", {req0_ready, req1_ready}); end
        e = ref_add(0, req0_a, req0_b, req0_cin);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_result(lat);
        n_vec++; if (got !== e) begin n_err++; $display("FAIL mid_result: got %h exp %h", got, e); end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    task automatic test_random();
        bit m_busy, m_ptr, has_g, g;
        int m_cnt, ops, cyc, w0, w1;
        do_reset();
        exp_q.delete();
        m_busy = 0; m_ptr = 0; m_cnt = 0; ops = 0; cyc = 0; w0 = 0; w1 = 0;
        while (ops < 10000 && cyc < 80000) begin
            req0_valid = ($urandom_range(0, 7) != 0);
            req1_valid = ($urandom_range(0, 7) != 0);
            req0_a = $urandom(); req0_b = $urandom(); req0_cin = 1'($urandom_range(0, 1));
            req1_a = $urandom(); req1_b = $urandom(); req1_cin = 1'($urandom_range(0, 1));
            res_ready = ($urandom_range(0, 3) != 0);
            #1;
            has_g = req0_valid | req1_valid;
            g = (req0_valid && req1_valid) ? m_ptr : req1_valid;
            if (!m_busy) begin
                n_vec++;
                if ({req0_ready, req1_ready, res_valid, busy} !== {has_g & ~g, has_g & g, 2'b00}) begin
                    n_err++;
                    $display("FAIL rnd_idle op%0d: got %b exp %b", ops, {req0_ready, req1_ready, res_valid, busy}, {has_g & ~g, has_g & g, 2'b00});
                end
            end else begin
                n_vec++;
                if ({req0_ready, req1_ready, res_valid, busy} !== {2'b00, m_cnt == N, 1'b1}) begin
                    n_err++;
                    $display("FAIL rnd_busy op%0d: got %b exp %b", ops, {req0_ready, req1_ready, res_valid, busy}, {2'b00, m_cnt == N, 1'b1});
                end
                if (m_cnt == N) begin
                    n_vec++;
                    if (got !== exp_q[0]) begin n_err++; $display("FAIL rnd_result op%0d: got %h exp %h", ops, got, exp_q[0]); end
                end
            end
            if (!req0_valid) w0 = 0;
            if (!req1_valid) w1 = 0;
            if (!m_busy && has_g) begin
                exp_q.push_back(g ? ref_add(1, req1_a, req1_b, req1_cin) : ref_add(0, req0_a, req0_b, req0_cin));
                if (g) begin w1 = 0; if (req0_valid) w0++; end
                else begin w0 = 0; if (req1_valid) w1++; end
                n_vec++;
                if (w0 > 1 || w1 > 1) begin n_err++; $display("FAIL rnd_starve op%0d: waits %0d/%0d exp <=1", ops, w0, w1); end
                m_busy = 1; m_cnt = 0; m_ptr = ~g; ops++;
            end else if (m_busy) begin
                if (m_cnt == N) begin
                    if (res_ready) begin
                        void'(exp_q.pop_front());
                        m_busy = 0;
                    end
                end else begin
                    m_cnt++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
        n_vec++; if (ops != 10000) begin n_err++; $display("FAIL rnd_ops: got %0d exp 10000", ops); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_alternate();
        test_backpressure();
        test_reset_mid_run();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
